axi_lite_master: RTL

//  Bridges the core's simple DBus AXI-region port (rd_en/wr_en/addr/busy) onto an AXI4-Lite master

---
 rtl/axi_lite_master.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master.sv
// axi_lite_master
//   Bridges the core's simple AXI-region request port (rd_en / wr_en / addr,
//   stalled by axi_busy) onto an AXI4-Lite master interface. One transaction
//   is in flight at a time; the core is held busy until the slave responds.
//   The result (read data and fault status) is presented for exactly one
//   DONE cycle.
//
//   Optional feature macro: AXI_LITE_TIMEOUT_EN
//     When defined, a response-wait counter aborts a transaction that has
//     not completed within TIMEOUT_CYCLES cycles. The abort reports a fault
//     with zero read data and treats the bus as hung. When undefined, the
//     block waits indefinitely.
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   axi_rd_en, axi_wr_en              core read / write request
//   axi_addr [AXI_ADDR_WIDTH]         core byte address (passed unaligned)
//   wr_data [32], wr_strobe [4]       core write data and byte strobes
//   axi_rd_data [32]                  read data, valid in the DONE cycle
//   axi_access_fault                  error response or timeout, DONE cycle
//   axi_busy                          core stall (combinational)
//   m_aw*, m_w*, m_b*, m_ar*, m_r*    AXI4-Lite master channels
//   m_awprot, m_arprot                tied to 3'b000
module axi_lite_master #(
    parameter int AXI_ADDR_WIDTH = 30,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      axi_rd_en,
    input  logic                      axi_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_addr,
    input  logic [31:0]               wr_data,
    input  logic [3:0]                wr_strobe,
    output logic [31:0]               axi_rd_data,
    output logic                      axi_access_fault,
    output logic                      axi_busy,
    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [2:0]                m_awprot,
    output logic [31:0]               m_wdata,
    output logic [3:0]                m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [2:0]                m_arprot,
    input  logic [31:0]               m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        WR_RESP = 3'd2,
        READ    = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state, state_nx;

    // Address/data handshakes are recorded here; the state machine advances
    // on the recorded flags, i.e. the cycle after the last handshake.
    logic aw_done, w_done, ar_done;
    logic tmo_hit;

    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;

    // Stall in the request cycle itself, and throughout the transaction.
    // Forced low while reset is asserted even if the core is requesting.
    assign axi_busy = rst_n &
                      (((state == IDLE) & (axi_rd_en | axi_wr_en)) |
                       ((state != IDLE) & (state != DONE)));

`ifdef AXI_LITE_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state == IDLE) || (state == DONE)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    assign tmo_hit = (state != IDLE) && (state != DONE) &&
                     (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    // Constant false: the wait limit only matters when the timeout is built in.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (axi_wr_en) begin
                    state_nx = WRITE;
                end else if (axi_rd_en) begin
                    state_nx = READ;
                end
            end
            WRITE: begin
                if (aw_done && w_done) begin
                    state_nx = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_bvalid) begin
                    state_nx = DONE;
                end
            end
            READ: begin
                if (ar_done) begin
                    state_nx = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_rvalid) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // A hung bus abandons the transaction; late responses are ignored.
        if (tmo_hit) begin
            state_nx = DONE;
        end
    end

    // Registered channel handshakes and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_awvalid        <= 1'b0;
            m_wvalid         <= 1'b0;
            m_bready         <= 1'b0;
            m_arvalid        <= 1'b0;
            m_rready         <= 1'b0;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            ar_done          <= 1'b0;
            axi_rd_data      <= 32'd0;
            axi_access_fault <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (axi_wr_en) begin
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                    end else if (axi_rd_en) begin
                        m_arvalid <= 1'b1;
                        ar_done   <= 1'b0;
                    end
                end
                WRITE: begin
                    // AW and W complete independently, in either order.
                    if (m_awvalid && m_awready) begin
                        m_awvalid <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (m_wvalid && m_wready) begin
                        m_wvalid <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if (aw_done && w_done) begin
                        m_bready <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (m_bvalid) begin
                        m_bready         <= 1'b0;
                        axi_access_fault <= (m_bresp != 2'b00);
                    end
                end
                READ: begin
                    if (m_arvalid && m_arready) begin
                        m_arvalid <= 1'b0;
                        ar_done   <= 1'b1;
                    end
                    if (ar_done) begin
                        m_rready <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (m_rvalid) begin
                        m_rready         <= 1'b0;
                        axi_rd_data      <= m_rdata;
                        axi_access_fault <= (m_rresp != 2'b00);
                    end
                end
                DONE: begin
                    axi_access_fault <= 1'b0;
                end
                default: begin
                end
            endcase
            if (tmo_hit) begin
                m_awvalid        <= 1'b0;
                m_wvalid         <= 1'b0;
                m_bready         <= 1'b0;
                m_arvalid        <= 1'b0;
                m_rready         <= 1'b0;
                axi_access_fault <= 1'b1;
                axi_rd_data      <= 32'd0;
            end
        end
    end

    // Request payload latch; the core holds it stable while busy anyway,
    // but the bus side must not depend on that.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (axi_wr_en) begin
                m_awaddr <= axi_addr;
                m_wdata  <= wr_data;
                m_wstrb  <= wr_strobe;
            end else if (axi_rd_en) begin
                m_araddr <= axi_addr;
            end
        end
    end

endmodule
